// File: rtl/pipe_control_unit_pkg.sv
// Shared types and constants for the pipelined control unit.
// Opcode is {instruction[13:12], instruction[5:4]}.
package pipe_ctrl_pkg;

    localparam int INSTR_W = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 3;

    localparam logic [3:0] OP_ADD    = 4'b0011;
    localparam logic [3:0] OP_SUB    = 4'b1011;
    localparam logic [3:0] OP_OR     = 4'b0111;
    localparam logic [3:0] OP_ADDI   = 4'b0001;
    localparam logic [3:0] OP_SUBI   = 4'b1001;
    localparam logic [3:0] OP_ORI    = 4'b0101;
    localparam logic [3:0] OP_LOAD   = 4'b1000;
    localparam logic [3:0] OP_STORE  = 4'b1010;
    localparam logic [3:0] OP_BRANCH = 4'b0010;

    typedef struct packed {
        logic [1:0]         imm_sel;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_write;
        logic               mem_to_reg;
        logic               reg_write;
        logic               is_load;
        logic               is_branch;
        logic               uses_rs2;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    // EX/MEM result is newer than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              exmem_rw,
        input logic [REG_AW-1:0] exmem_rd,
        input logic              memwb_rw,
        input logic [REG_AW-1:0] memwb_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0 && exmem_rw && exmem_rd == rs)
            sel = 2'b10;
        else if (rs != '0 && memwb_rw && memwb_rd == rs)
            sel = 2'b01;
        return sel;
    endfunction

endpackage

// File: rtl/pipe_control_unit_if.sv
// Bus between the IF/ID register / datapath and the pipelined control unit.
// PIPE_PERF_CNT_EN adds the stall/flush event counters.
interface pipe_control_unit_if;
    import pipe_ctrl_pkg::*;

    logic                     instr_valid;
    logic [INSTR_W-1:0]       instruction;
    logic                     ex_zero;
    logic [1:0]               ex_imm_sel;
    logic                     ex_alu_src;
    logic [ALUOP_W-1:0]       ex_alu_op;
    logic [1:0]               fwd_a;
    logic [1:0]               fwd_b;
    logic                     mem_write;
    logic                     wb_mem_to_reg;
    logic                     wb_reg_write;
    logic [REG_AW-1:0]        wb_rd;
    logic                     pc_src;
    logic                     stall;
    logic                     flush;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]              stall_cnt;
    logic [31:0]              flush_cnt;

    modport master (
        output instr_valid, instruction, ex_zero,
        input  ex_imm_sel, ex_alu_src, ex_alu_op, fwd_a, fwd_b, mem_write,
               wb_mem_to_reg, wb_reg_write, wb_rd, pc_src, stall, flush,
               stall_cnt, flush_cnt
    );
    modport slave (
        input  instr_valid, instruction, ex_zero,
        output ex_imm_sel, ex_alu_src, ex_alu_op, fwd_a, fwd_b, mem_write,
               wb_mem_to_reg, wb_reg_write, wb_rd, pc_src, stall, flush,
               stall_cnt, flush_cnt
    );
`else
    modport master (
        output instr_valid, instruction, ex_zero,
        input  ex_imm_sel, ex_alu_src, ex_alu_op, fwd_a, fwd_b, mem_write,
               wb_mem_to_reg, wb_reg_write, wb_rd, pc_src, stall, flush
    );
    modport slave (
        input  instr_valid, instruction, ex_zero,
        output ex_imm_sel, ex_alu_src, ex_alu_op, fwd_a, fwd_b, mem_write,
               wb_mem_to_reg, wb_reg_write, wb_rd, pc_src, stall, flush
    );
`endif

endinterface

// File: rtl/pipe_control_unit_ctrl_decoder.sv
// Combinational ID-stage decoder: opcode -> control bundle.
// Unknown opcodes and invalid slots decode to a bubble.
module ctrl_decoder
    import pipe_ctrl_pkg::*;
(
    input  logic         i_valid,
    input  logic [3:0]   i_opcode,
    output ctrl_bundle_t o_ctrl
);

    always_comb begin
        o_ctrl = BUBBLE;
        if (i_valid) begin
            case (i_opcode)
                OP_ADD, OP_SUB, OP_OR: begin
                    o_ctrl.alu_op     = (i_opcode == OP_SUB) ? 3'b001 :
                                        (i_opcode == OP_OR)  ? 3'b010 : 3'b000;
                    o_ctrl.mem_to_reg = 1'b1;
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.uses_rs2   = 1'b1;
                end
                OP_ADDI, OP_SUBI, OP_ORI: begin
                    o_ctrl.alu_op     = (i_opcode == OP_SUBI) ? 3'b001 :
                                        (i_opcode == OP_ORI)  ? 3'b010 : 3'b000;
                    o_ctrl.alu_src    = 1'b1;
                    o_ctrl.imm_sel    = 2'b01;
                    o_ctrl.mem_to_reg = 1'b1;
                    o_ctrl.reg_write  = 1'b1;
                end
                OP_LOAD: begin
                    o_ctrl.alu_src   = 1'b1;
                    o_ctrl.imm_sel   = 2'b01;
                    o_ctrl.reg_write = 1'b1;
                    o_ctrl.is_load   = 1'b1;
                end
                OP_STORE: begin
                    o_ctrl.alu_src   = 1'b1;
                    o_ctrl.imm_sel   = 2'b10;
                    o_ctrl.mem_write = 1'b1;
                    o_ctrl.uses_rs2  = 1'b1;
                end
                OP_BRANCH: begin
                    o_ctrl.imm_sel   = 2'b11;
                    o_ctrl.alu_op    = 3'b011;
                    o_ctrl.is_branch = 1'b1;
                    o_ctrl.uses_rs2  = 1'b1;
                end
                default: o_ctrl = BUBBLE;
            endcase
        end
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall, EX branch flush and forwarding. PIPE_PERF_CNT_EN adds counters.
module pipe_control_unit
    import pipe_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    pipe_control_unit_if.slave bus
);

    logic [3:0]        w_opcode;
    ctrl_bundle_t      w_dec;
    logic              w_id_real;
    logic [REG_AW-1:0] w_id_rd, w_id_rs1, w_id_rs2;
    logic              w_br_taken, w_load_use;
    logic              w_unused_bits;

    ctrl_bundle_t      r_idex_ctrl;
    logic [REG_AW-1:0] r_idex_rd, r_idex_rs1, r_idex_rs2;
    logic              r_exmem_mem_write, r_exmem_mem_to_reg, r_exmem_reg_write;
    logic [REG_AW-1:0] r_exmem_rd;
    logic              r_memwb_mem_to_reg, r_memwb_reg_write;
    logic [REG_AW-1:0] r_memwb_rd;

    assign w_opcode = {bus.instruction[13:12], bus.instruction[5:4]};
    assign w_id_rd  = bus.instruction[11:7];
    assign w_id_rs1 = bus.instruction[19:15];
    assign w_id_rs2 = bus.instruction[24:20];
    assign w_unused_bits = ^{bus.instruction[31:25], bus.instruction[6],
                             bus.instruction[3:0], r_idex_ctrl.uses_rs2};

    ctrl_decoder u_dec (
        .i_valid  (bus.instr_valid),
        .i_opcode (w_opcode),
        .o_ctrl   (w_dec)
    );

    assign w_id_real  = w_dec.reg_write | w_dec.mem_write | w_dec.is_branch;
    assign w_br_taken = r_idex_ctrl.is_branch & bus.ex_zero;
    assign w_load_use = r_idex_ctrl.is_load && (r_idex_rd != '0) && w_id_real &&
                        ((r_idex_rd == w_id_rs1) ||
                         (w_dec.uses_rs2 && (r_idex_rd == w_id_rs2)));

    // A taken branch squashes the ID slot, so it overrides any stall request.
    assign bus.pc_src = w_br_taken;
    assign bus.flush  = w_br_taken;
    assign bus.stall  = w_load_use & ~w_br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex_ctrl <= BUBBLE;
            r_idex_rd   <= '0;
            r_idex_rs1  <= '0;
            r_idex_rs2  <= '0;
        end else if (w_br_taken || w_load_use || !w_id_real) begin
            r_idex_ctrl <= BUBBLE;
            r_idex_rd   <= '0;
            r_idex_rs1  <= '0;
            r_idex_rs2  <= '0;
        end else begin
            r_idex_ctrl <= w_dec;
            r_idex_rd   <= w_id_rd;
            r_idex_rs1  <= w_id_rs1;
            r_idex_rs2  <= w_id_rs2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exmem_mem_write  <= 1'b0;
            r_exmem_mem_to_reg <= 1'b0;
            r_exmem_reg_write  <= 1'b0;
            r_exmem_rd         <= '0;
            r_memwb_mem_to_reg <= 1'b0;
            r_memwb_reg_write  <= 1'b0;
            r_memwb_rd         <= '0;
        end else begin
            r_exmem_mem_write  <= r_idex_ctrl.mem_write;
            r_exmem_mem_to_reg <= r_idex_ctrl.mem_to_reg;
            r_exmem_reg_write  <= r_idex_ctrl.reg_write;
            r_exmem_rd         <= r_idex_rd;
            r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
            r_memwb_reg_write  <= r_exmem_reg_write;
            r_memwb_rd         <= r_exmem_rd;
        end
    end

    assign bus.ex_imm_sel    = r_idex_ctrl.imm_sel;
    assign bus.ex_alu_src    = r_idex_ctrl.alu_src;
    assign bus.ex_alu_op     = r_idex_ctrl.alu_op;
    assign bus.mem_write     = r_exmem_mem_write;
    assign bus.wb_mem_to_reg = r_memwb_mem_to_reg;
    assign bus.wb_reg_write  = r_memwb_reg_write;
    assign bus.wb_rd         = r_memwb_rd;
    assign bus.fwd_a = fwd_sel(r_idex_rs1, r_exmem_reg_write, r_exmem_rd,
                               r_memwb_reg_write, r_memwb_rd);
    assign bus.fwd_b = fwd_sel(r_idex_rs2, r_exmem_reg_write, r_exmem_rd,
                               r_memwb_reg_write, r_memwb_rd);

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.stall && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (bus.flush && r_flush_cnt != 32'hFFFF_FFFF)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// Testbench for pipe_control_unit: directed steps plus randomized instruction
// stream checked every cycle against a stage-slot reference model.
module tb_pipe_control_unit;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_control_unit_if bus();

    pipe_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        bit       rw, m2r, mw, ld, br, u2;
        bit [1:0] imm;
        bit       src;
        bit [2:0] alu;
        bit [4:0] rd, rs1, rs2;
    } slot_t;

    slot_t       m_ex, m_mem, m_wb;
    int unsigned m_scnt, m_fcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t spec_decode(input bit v, input bit [31:0] ins);
        slot_t s;
        bit [3:0] op;
        s  = '0;
        op = {ins[13:12], ins[5:4]};
        if (!v) return s;
        case (op)
            4'b0011: begin s.alu = 3'd0; s.rw = 1; s.m2r = 1; s.u2 = 1; end
            4'b1011: begin s.alu = 3'd1; s.rw = 1; s.m2r = 1; s.u2 = 1; end
            4'b0111: begin s.alu = 3'd2; s.rw = 1; s.m2r = 1; s.u2 = 1; end
            4'b0001: begin s.alu = 3'd0; s.rw = 1; s.m2r = 1; s.src = 1; s.imm = 2'b01; end
            4'b1001: begin s.alu = 3'd1; s.rw = 1; s.m2r = 1; s.src = 1; s.imm = 2'b01; end
            4'b0101: begin s.alu = 3'd2; s.rw = 1; s.m2r = 1; s.src = 1; s.imm = 2'b01; end
            4'b1000: begin s.rw = 1; s.ld = 1; s.src = 1; s.imm = 2'b01; end
            4'b1010: begin s.mw = 1; s.src = 1; s.imm = 2'b10; s.u2 = 1; end
            4'b0010: begin s.br = 1; s.alu = 3'd3; s.imm = 2'b11; s.u2 = 1; end
            default: return s;
        endcase
        s.rd  = ins[11:7];
        s.rs1 = ins[19:15];
        s.rs2 = ins[24:20];
        return s;
    endfunction

    function automatic bit [1:0] model_fwd(input bit [4:0] rs);
        if (rs != 0 && m_mem.rw && m_mem.rd == rs) return 2'b10;
        if (rs != 0 && m_wb.rw && m_wb.rd == rs)   return 2'b01;
        return 2'b00;
    endfunction

    // Compare every output against the model for the inputs currently driven.
    task automatic compare_now(input string p, output bit br_t, output bit lu, output slot_t d);
        bit real_id;
        d       = spec_decode(bus.instr_valid, bus.instruction);
        real_id = d.rw | d.mw | d.br;
        br_t    = m_ex.br && bus.ex_zero;
        lu      = m_ex.ld && m_ex.rd != 0 && real_id &&
                  (m_ex.rd == d.rs1 || (d.u2 && m_ex.rd == d.rs2));
        chk({p, ":ex_imm_sel"},    bus.ex_imm_sel,    m_ex.imm);
        chk({p, ":ex_alu_src"},    bus.ex_alu_src,    m_ex.src);
        chk({p, ":ex_alu_op"},     bus.ex_alu_op,     m_ex.alu);
        chk({p, ":fwd_a"},         bus.fwd_a,         model_fwd(m_ex.rs1));
        chk({p, ":fwd_b"},         bus.fwd_b,         model_fwd(m_ex.rs2));
        chk({p, ":mem_write"},     bus.mem_write,     m_mem.mw);
        chk({p, ":wb_mem_to_reg"}, bus.wb_mem_to_reg, m_wb.m2r);
        chk({p, ":wb_reg_write"},  bus.wb_reg_write,  m_wb.rw);
        chk({p, ":wb_rd"},         bus.wb_rd,         m_wb.rd);
        chk({p, ":pc_src"},        bus.pc_src,        br_t);
        chk({p, ":flush"},         bus.flush,         br_t);
        chk({p, ":stall"},         bus.stall,         lu && !br_t);
`ifdef PIPE_PERF_CNT_EN
        chk({p, ":stall_cnt"},     bus.stall_cnt,     m_scnt);
        chk({p, ":flush_cnt"},     bus.flush_cnt,     m_fcnt);
`endif
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input bit v, input bit [31:0] ins, input bit z,
                         output bit exp_st, output bit obs_st, output bit obs_fl);
        bit br_t, lu;
        slot_t d;
        bus.instr_valid = v;
        bus.instruction = ins;
        bus.ex_zero     = z;
        #1;
        compare_now("cyc", br_t, lu, d);
        exp_st = lu && !br_t;
        obs_st = bus.stall;
        obs_fl = bus.flush;
        @(posedge clk);
        if (exp_st && m_scnt != 32'hFFFF_FFFF) m_scnt++;
        if (br_t && m_fcnt != 32'hFFFF_FFFF)   m_fcnt++;
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = (br_t || lu) ? '0 : d;
        @(negedge clk);
    endtask

    task automatic reset_phase(input int n, input bit [31:0] ins);
        bit br_t, lu;
        slot_t d;
        rst_n = 1'b0;
        m_ex = '0; m_mem = '0; m_wb = '0; m_scnt = 0; m_fcnt = 0;
        bus.instr_valid = 1'b1;
        bus.instruction = ins;
        bus.ex_zero     = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            compare_now("rst", br_t, lu, d);
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    function automatic bit [31:0] gen_instr();
        bit [31:0] r;
        bit [3:0]  op;
        int        k;
        r = $urandom;
        k = $urandom_range(0, 10);
        if (k == 10) return r;
        case (k)
            0: op = 4'b0011;  1: op = 4'b1011;  2: op = 4'b0111;
            3: op = 4'b0001;  4: op = 4'b1001;  5: op = 4'b0101;
            6, 7: op = 4'b1000;
            8: op = 4'b1010;
            default: op = 4'b0010;
        endcase
        r[13:12] = op[3:2];
        r[5:4]   = op[1:0];
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        bit est, ost, ofl;
        bit [31:0] cur;
        bit cur_v;

        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        bus.ex_zero     = 1'b0;
        @(negedge clk);

        // Reset with an add presented, then that add reaches write-back.
        reset_phase(2, 32'h0000_0030);
        cycle(1, 32'h0000_0030, 0, est, ost, ofl);
        chk("rst_ex_alu_op", bus.ex_alu_op, 3'b000);
        chk("rst_ex_alu_src", bus.ex_alu_src, 1'b0);
        cycle(0, 0, 0, est, ost, ofl);
        cycle(0, 0, 0, est, ost, ofl);
        chk("rst_wb_reg_write", bus.wb_reg_write, 1'b1);

        // Load-use: one stall, then the add issues with MEM/WB forwarding.
        cycle(1, 32'h0000_2280, 0, est, ost, ofl);
        cycle(1, 32'h0002_8030, 0, est, ost, ofl);
        chk("lu_stall", ost, 1'b1);
        chk("lu_bubble_op", bus.ex_alu_src, 1'b0);
        cycle(1, 32'h0002_8030, 0, est, ost, ofl);
        chk("lu_no_2nd_stall", ost, 1'b0);
        chk("lu_fwd_a", bus.fwd_a, 2'b01);
        repeat (3) cycle(0, 0, 0, est, ost, ofl);

        // Back-to-back ALU: x3 forwards from EX/MEM; x0 never forwards.
        cycle(1, 32'h0000_01B0, 0, est, ost, ofl);
        cycle(1, 32'h0001_8030, 0, est, ost, ofl);
        chk("b2b_stall", ost, 1'b0);
        chk("b2b_fwd_a", bus.fwd_a, 2'b10);
        repeat (3) cycle(0, 0, 0, est, ost, ofl);
        cycle(1, 32'h0000_0030, 0, est, ost, ofl);
        cycle(1, 32'h0000_0030, 0, est, ost, ofl);
        chk("x0_fwd_a", bus.fwd_a, 2'b00);
        repeat (3) cycle(0, 0, 0, est, ost, ofl);

        // Taken branch squashes the following add (which would also hazard-free issue).
        cycle(1, 32'h0000_0020, 0, est, ost, ofl);
        cycle(1, 32'h0000_01B0, 1, est, ost, ofl);
        chk("br_flush", ofl, 1'b1);
        chk("br_stall", ost, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, est, ost, ofl);
            chk("br_squash_wb", bus.wb_reg_write, 1'b0);
        end

        // Store: mem_write two cycles after decode, no write-back.
        cycle(1, 32'h0000_2020, 0, est, ost, ofl);
        cycle(0, 0, 0, est, ost, ofl);
        chk("st_mem_write", bus.mem_write, 1'b1);
        cycle(0, 0, 0, est, ost, ofl);
        chk("st_wb_reg_write", bus.wb_reg_write, 1'b0);
        repeat (2) cycle(0, 0, 0, est, ost, ofl);

        // Random stream; IF holds the instruction while stalled.
        cur   = gen_instr();
        cur_v = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) reset_phase(2, cur);
            cycle(cur_v, cur, 1'($urandom_range(0, 1)), est, ost, ofl);
            if (!est) begin
                cur   = gen_instr();
                cur_v = ($urandom_range(0, 7) != 0);
            end
        end

        // Event counting: three stalls then two flushes.
        @(negedge clk);
        reset_phase(1, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 32'h0000_2280, 0, est, ost, ofl);
            cycle(1, 32'h0002_8030, 0, est, ost, ofl);
            cycle(1, 32'h0002_8030, 0, est, ost, ofl);
            repeat (2) cycle(0, 0, 0, est, ost, ofl);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1, 32'h0000_0020, 0, est, ost, ofl);
            cycle(0, 0, 1, est, ost, ofl);
        end
`ifdef PIPE_PERF_CNT_EN
        chk("perf_stall_cnt", bus.stall_cnt, 32'd3);
        chk("perf_flush_cnt", bus.flush_cnt, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
Pipelined successor to the single-cycle decoder. It decodes the instruction in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards (stall), resolves branches in EX (flush) and generates operand-forwarding selects. It sits between the IF/ID instruction register and the datapath stage muxes.

Parameters:
INSTR_W, 32, instruction width
REG_AW, 5, register address width; rd=[11:7], rs1=[19:15], rs2=[24:20]
ALUOP_W, 3, ALU op width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
instr_valid  in  1  IF/ID holds a valid instruction
instruction  in  INSTR_W  instruction in ID
ex_zero  in  1  ALU zero flag of the EX-stage instruction
ex_imm_sel  out  2  ID/EX immSel
ex_alu_src  out  1  ID/EX ALU B source (1=imm)
ex_alu_op  out  ALUOP_W  ID/EX ALU op
fwd_a, fwd_b  out  2  operand forward select: 00 reg file, 10 EX/MEM, 01 MEM/WB
mem_write  out  1  EX/MEM store enable
wb_mem_to_reg  out  1  MEM/WB select (1=ALU, 0=memory)
wb_reg_write  out  1  MEM/WB register write enable
wb_rd  out  REG_AW  MEM/WB destination
pc_src  out  1  take branch target
stall  out  1  hold PC and IF/ID
flush  out  1  squash IF/ID

Behaviour:
- Clock and reset decided: single clock clk; reset rst_n is asynchronous, active-low.
- Decode opcode = {instruction[13:12], instruction[5:4]}.
  - R add/sub/or: 0011/1011/0111 -> alu 000/001/010, src 0, imm 00, wb ALU, regwrite.
  - I forms: 0001/1001/0101 -> alu 000/001/010, src 1, imm 01, wb ALU, regwrite.
  - Load 1000: alu 000, src 1, imm 01, memToReg 0, regwrite.
  - Store 1010: imm 10, src 1, mem_write, no regwrite.
  - Branch 0010: imm 11, alu 011, no regwrite.
  - Other opcodes, or instr_valid=0: bubble (all controls 0).
- rs2 is used only by R, store and branch.
- Pipeline registers advance every cycle; there is no external enable.
- Reset: every stage register clears to bubble, including rd=0. All outputs read 0 while rst_n=0 and on the first cycle after release.
- Load-use hazard: ID/EX is a load, its rd≠0, and its rd equals the decoding rs1, or rs2 when rs2 is used. Then:
  - stall=1 (combinational) and a bubble is written into ID/EX.
  - The instruction remains in ID and re-decodes next cycle, at which point it issues.
- Branch, resolved in EX: ID/EX is a branch and ex_zero=1. Then:
  - pc_src=1 and flush=1 (combinational) for that cycle.
  - A bubble is written into ID/EX, squashing the ID instruction.
- Branch not taken: no effect.
- Simultaneous branch-taken and load-use hazard: the branch wins; stall=0, flush=1.
- Forwarding for the operands of the instruction in EX (ID/EX rs1/rs2):
  - EX/MEM regwrite, rd≠0, rd match -> 10.
  - Else MEM/WB regwrite, rd≠0, rd match -> 01.
  - Else 00.
  - EX/MEM takes priority over MEM/WB.
- Register x0 never triggers a stall or a forward.
- Latency: decode to EX outputs 1 cycle; mem_write 2 cycles; wb_* 3 cycles.
- Reset asserted mid-operation: in-flight instructions are lost; no partial write-back.

Optional Feature:
PIPE_PERF_CNT_EN:
- When defined, adds outputs stall_cnt[31:0] and flush_cnt[31:0].
- Each counter increments on every cycle its event is asserted, saturates at 32'hFFFFFFFF, and clears on reset.
- When undefined, the ports and logic are absent.

Decomposition:
- Package pipe_ctrl_pkg: opcode localparams, a ctrl_bundle_t struct (imm_sel, alu_src, alu_op, mem_write, mem_to_reg, reg_write, is_load, is_branch, uses_rs2), and a BUBBLE constant.
- One sub-module, ctrl_decoder: combinational opcode -> ctrl_bundle_t.
- Hazard, forwarding and pipeline registers stay in the top.

Test Plan:
- Reset: hold rst_n=0, drive 32'h00000030 -> every output 0; after release, ex_alu_op=000, wb_reg_write=1 three cycles later.
- Load-use: 32'h00002280 (load x5), then 32'h00028030 (add rs1=x5) -> stall=1 exactly one cycle, bubble in EX, add issues next cycle with fwd_a=01.
- Back-to-back ALU: rd=x3 add, then an add with rs1=x3 -> fwd_a=10, no stall; with rd=x0 instead -> fwd_a=00.
- Branch taken: 32'h00000020 with ex_zero=1 in its EX cycle -> pc_src=1, flush=1 for one cycle, following instruction never reaches mem/wb.
- Branch plus load-use in the same cycle -> flush=1, stall=0; store 32'h00002020 -> mem_write=1 two cycles after decode, wb_reg_write=0.
- PIPE_PERF_CNT_EN defined: three stalls and two flushes -> stall_cnt=3, flush_cnt=2.
